ldpc_demux_tree: RTL and testbench
==================================

LDPC_DEMUX_TREE -- requirements
Module: ldpc_demux_tree

Interface
REQ-001 Parameter WIDTH, default 8: message word width in bits.
REQ-002 Parameter NUM_RAMS, default 24: number of message RAMs; RA = $clog2(NUM_RAMS) (5 at default).
REQ-003 Parameter EXPANSION_FACTOR, default 96: offset/shift vector width in bits.
REQ-004 Parameter FROM_RAM, default 0: RAM index this tree serves; words tagged with another RAM are rejected.
REQ-005 The block SHALL use one clock, i_clock, and an asynchronous, active-high reset, i_reset.
REQ-006 Port list (name, direction, width, meaning):
- i_clock  input  1  clock.
- i_reset  input  1  asynchronous active-high reset.
- i_data  input  WIDTH  word read from the RAM.
- i_offset  input  EXPANSION_FACTOR  offset vector travelling with the word.
- i_ram_addr  input  RA  source RAM tag.
- i_to_branch  input  3  destination branch index, 0..7.
- i_valid  input  1  input word valid.
- o_data  output  8*WIDTH  per-branch word; lane b = bits [b*WIDTH +: WIDTH].
- o_offset  output  8*EXPANSION_FACTOR  per-branch offset; lane b = bits [b*EXPANSION_FACTOR +: EXPANSION_FACTOR].
- o_valid  output  8  per-branch valid, one-hot or zero.
- o_busy  output  1  at least one accepted word in flight.
- o_drop_count  output  16  saturating count of rejected words.

Function
REQ-007 Accept: i_valid=1 and i_ram_addr==FROM_RAM; reject: i_valid=1 and i_ram_addr!=FROM_RAM.
REQ-008 Pipeline: input register (stage 0), three binary split stages (1..3), output register; latency = 5 cycles from an accepted input edge to the matching o_valid bit.
REQ-009 Throughput: one word per cycle, no backpressure, no bubbles inserted; back-to-back words keep order and spacing.
REQ-010 Split stage k (k=1,2,3) SHALL steer valid by i_to_branch bit (3-k): stage 1 by bit 2, stage 2 by bit 1, stage 3 by bit 0; 0 selects the lower child, 1 the upper child.
REQ-011 Each split stage SHALL copy data and offset to both children unconditionally (fan-out register); only valid is steered.
REQ-012 Consequence: o_valid[b]=1 exactly when an accepted word with i_to_branch==b emerges; all other o_valid bits SHALL be 0 that cycle.
REQ-013 o_data/o_offset lanes SHALL all carry the emerging word's data/offset whenever any o_valid bit is 1; lane contents are don't-care when o_valid==0.
REQ-014 Rejected words SHALL NOT enter the valid pipeline; stage-0 valid is 0 for that cycle.
REQ-015 o_drop_count SHALL increment by 1 on each rejected word, registered (visible 1 cycle after the rejecting edge), saturating at 16'hFFFF.
REQ-016 o_busy SHALL be the registered OR of all stage valids (0..3); it is 1 from the cycle after the first acceptance until the cycle the last o_valid is asserted, inclusive.
REQ-017 i_valid=0 cycles SHALL propagate as zero valids; data/offset registers may load any value.
REQ-018 Datapath registers (data, offset) are not reset; all valid registers, o_valid, o_busy and o_drop_count are reset.

Reset
REQ-019 While i_reset=1: o_valid=8'h00, o_busy=0, o_drop_count=16'h0000, asynchronously, regardless of i_clock.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight words; no o_valid bit asserts for them after release.
REQ-021 First input accepted at the first rising edge after reset deassertion; its o_valid appears 5 cycles later.

Verification
REQ-022 FROM_RAM=0; single word i_data=8'hA5, i_offset=96'h1, i_ram_addr=0, i_to_branch=5 -> 5 edges later o_valid=8'b0010_0000, o_data lane 5=8'hA5, o_offset lane 5=96'h1; o_valid=0 on every other cycle.
REQ-023 Eight consecutive accepted words, i_to_branch=0..7, i_data=8'h10..8'h17 -> o_valid = 8'h01, 8'h02, ..., 8'h80 on 8 consecutive cycles, each with the matching data; o_busy high continuously for those cycles.
REQ-024 i_ram_addr=3 with FROM_RAM=0, i_valid=1 for 4 cycles -> o_valid stays 8'h00, o_busy stays 0, o_drop_count reads 4.
REQ-025 Saturation: preload via 65,537 rejected words -> o_drop_count holds 16'hFFFF and does not wrap.
REQ-026 Three accepted words issued, i_reset pulsed for 1 cycle 2 edges later -> o_valid, o_busy, o_drop_count go to 0 immediately and no o_valid asserts afterwards; a new word with i_to_branch=2 issued after release -> o_valid=8'h04 5 cycles later.
REQ-027 Alternating accept/reject each cycle for 10 cycles (i_to_branch=7) -> exactly 5 pulses on o_valid[7], separated by 1 idle cycle; o_drop_count=5.

Source files
------------

// File: rtl/ldpc_demux_tree.sv
// rtl/ldpc_demux_tree.sv - one-to-eight LDPC message demux tree with RAM tag filtering
// Valid is steered through three binary split stages; data and offset fan out to every lane.
module ldpc_demux_tree #(
  parameter int WIDTH            = 8,
  parameter int NUM_RAMS         = 24,
  parameter int EXPANSION_FACTOR = 96,
  parameter int FROM_RAM         = 0,
  localparam int RA              = $clog2(NUM_RAMS)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [WIDTH-1:0]              i_data,
  input  logic [EXPANSION_FACTOR-1:0]   i_offset,
  input  logic [RA-1:0]                 i_ram_addr,
  input  logic [2:0]                    i_to_branch,
  input  logic                          i_valid,
  output logic [8*WIDTH-1:0]            o_data,
  output logic [8*EXPANSION_FACTOR-1:0] o_offset,
  output logic [7:0]                    o_valid,
  output logic                          o_busy,
  output logic [15:0]                   o_drop_count
);

  logic accept, reject;

  logic                                  v0_q, v0_d;
  logic [1:0]                            v1_q, v1_d;
  logic [3:0]                            v2_q, v2_d;
  logic [7:0]                            v3_q, v3_d;
  logic [7:0]                            valid_q;
  logic                                  busy_q, busy_d;
  logic [15:0]                           drop_q, drop_d;

  logic [WIDTH-1:0]                      d0_q;
  logic [EXPANSION_FACTOR-1:0]           f0_q;
  logic [2:0]                            b0_q;
  logic [1:0][WIDTH-1:0]                 d1_q;
  logic [1:0][EXPANSION_FACTOR-1:0]      f1_q;
  logic [1:0][1:0]                       b1_q;
  logic [3:0][WIDTH-1:0]                 d2_q;
  logic [3:0][EXPANSION_FACTOR-1:0]      f2_q;
  logic [3:0]                            b2_q;
  logic [7:0][WIDTH-1:0]                 d3_q;
  logic [7:0][EXPANSION_FACTOR-1:0]      f3_q;
  logic [7:0][WIDTH-1:0]                 od_q;
  logic [7:0][EXPANSION_FACTOR-1:0]      of_q;

  assign accept = i_valid && (i_ram_addr == RA'(FROM_RAM));
  assign reject = i_valid && (i_ram_addr != RA'(FROM_RAM));

  // Each stage consumes the most significant remaining branch bit; 0 -> lower child.
  always_comb begin
    v0_d = accept;
    v1_d = '0;
    v2_d = '0;
    v3_d = '0;
    for (int c = 0; c < 2; c++) begin
      v1_d[c] = v0_q && (b0_q[2] == c[0]);
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 2; c++) begin
        v2_d[2*p+c] = v1_q[p] && (b1_q[p][1] == c[0]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2; c++) begin
        v3_d[2*p+c] = v2_q[p] && (b2_q[p] == c[0]);
      end
    end
    // Includes the incoming accept so busy rises the cycle after acceptance,
    // and the last stage so busy stays high through the final o_valid cycle.
    busy_d = v0_d | v0_q | (|v1_q) | (|v2_q) | (|v3_q);
    drop_d = drop_q;
    if (reject && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      v0_q    <= 1'b0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      valid_q <= v3_q;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Datapath is free-running and unreset; only the valid path qualifies it.
  always_ff @(posedge i_clock) begin
    d0_q <= i_data;
    f0_q <= i_offset;
    b0_q <= i_to_branch;
    for (int c = 0; c < 2; c++) begin
      d1_q[c] <= d0_q;
      f1_q[c] <= f0_q;
      b1_q[c] <= b0_q[1:0];
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 2; c++) begin
        d2_q[2*p+c] <= d1_q[p];
        f2_q[2*p+c] <= f1_q[p];
        b2_q[2*p+c] <= b1_q[p][0];
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2; c++) begin
        d3_q[2*p+c] <= d2_q[p];
        f3_q[2*p+c] <= f2_q[p];
      end
    end
    for (int l = 0; l < 8; l++) begin
      od_q[l] <= d3_q[l];
      of_q[l] <= f3_q[l];
    end
  end

  assign o_data       = od_q;
  assign o_offset     = of_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_ldpc_demux_tree.sv
// tb/tb_ldpc_demux_tree.sv - directed self-checking bench for ldpc_demux_tree
module tb_ldpc_demux_tree;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   data = '0;
  logic [95:0]  off = '0;
  logic [4:0]   addr = '0;
  logic [2:0]   br = '0;
  logic         vld = 1'b0;
  logic [63:0]  o_data;
  logic [767:0] o_offset;
  logic [7:0]   o_valid;
  logic         o_busy;
  logic [15:0]  o_drop_count;

  int total = 0;
  int passed = 0;
  int pulses;
  logic [7:0] ev;

  ldpc_demux_tree dut (
    .i_clock(clk), .i_reset(rst), .i_data(data), .i_offset(off),
    .i_ram_addr(addr), .i_to_branch(br), .i_valid(vld),
    .o_data(o_data), .o_offset(o_offset), .o_valid(o_valid),
    .o_busy(o_busy), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [2:0] b,
                       input logic [7:0] d, input logic [95:0] o);
    vld = v; addr = a; br = b; data = d; off = o;
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
    chk("rst_valid", 96'(o_valid), 96'h0);
    chk("rst_busy", 96'(o_busy), 96'h0);
    chk("rst_drop", 96'(o_drop_count), 96'h0);
    step(); step();
    rst = 1'b0;

    // Single word to branch 5
    drive(1, 5'd0, 3'd5, 8'hA5, 96'h1);
    step();
    drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("single_idle", 96'(o_valid), 96'h0);
    end
    step();
    chk("single_valid", 96'(o_valid), 96'h20);
    chk("single_data", 96'(o_data[5*8 +: 8]), 96'hA5);
    chk("single_off", o_offset[5*96 +: 96], 96'h1);
    chk("single_busy", 96'(o_busy), 96'h1);
    step();
    chk("single_after", 96'(o_valid), 96'h0);
    chk("single_busy_off", 96'(o_busy), 96'h0);

    // Eight back-to-back words, branches 0..7
    for (int k = 0; k < 13; k++) begin
      if (k < 8) drive(1, 5'd0, 3'(k), 8'(8'h10 + k), 96'(k));
      else drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
      step();
      if (k >= 4 && k < 12) begin
        chk("burst_valid", 96'(o_valid), 96'(8'h01 << (k - 4)));
        chk("burst_data", 96'(o_data[(k-4)*8 +: 8]), 96'(8'h10 + k - 4));
        chk("burst_data_fan", 96'(o_data[(11-k)*8 +: 8]), 96'(8'h10 + k - 4));
        chk("burst_busy", 96'(o_busy), 96'h1);
      end else begin
        chk("burst_idle", 96'(o_valid), 96'h0);
      end
    end

    // Four rejected words
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd3, 3'd1, 8'hEE, 96'h0);
      step();
      chk("rej_busy", 96'(o_busy), 96'h0);
    end
    chk("rej_drop", 96'(o_drop_count), 96'd4);
    drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rej_valid", 96'(o_valid), 96'h0);
    end

    // Mid-flight reset discards words
    drive(1, 5'd0, 3'd0, 8'h31, 96'h0); step();
    drive(1, 5'd0, 3'd1, 8'h32, 96'h0); step();
    drive(1, 5'd0, 3'd3, 8'h33, 96'h0); step();
    drive(0, 5'd0, 3'd0, 8'h00, 96'h0); step();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 96'(o_valid), 96'h0);
    chk("mid_rst_busy", 96'(o_busy), 96'h0);
    chk("mid_rst_drop", 96'(o_drop_count), 96'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_idle", 96'({o_busy, o_valid}), 96'h0);
    end
    drive(1, 5'd0, 3'd2, 8'h5C, 96'hABC); step();
    drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
    step(); step(); step();
    chk("post_rst_early", 96'(o_valid), 96'h0);
    step();
    chk("post_rst_valid", 96'(o_valid), 96'h04);
    chk("post_rst_data", 96'(o_data[2*8 +: 8]), 96'h5C);
    chk("post_rst_off", o_offset[0 +: 96], 96'hABC);

    // Alternating accept/reject to branch 7
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 10) drive(1, (k % 2 == 0) ? 5'd0 : 5'd3, 3'd7, 8'(k), 96'h0);
      else drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
      step();
      ev = (k >= 4 && k <= 12 && (k % 2 == 0)) ? 8'h80 : 8'h00;
      chk("alt_valid", 96'(o_valid), 96'(ev));
      if (o_valid[7]) pulses = pulses + 1;
      if (ev != 8'h00) chk("alt_data", 96'(o_data[7*8 +: 8]), 96'(k - 4));
    end
    chk("alt_pulses", 96'(pulses), 96'd5);
    chk("alt_drop", 96'(o_drop_count), 96'd5);

    // Saturation of the drop counter
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 5'd3, 3'd0, 8'h00, 96'h0);
    repeat (65534) step();
    chk("sat_fffe", 96'(o_drop_count), 96'hFFFE);
    repeat (3) step();
    drive(0, 5'd0, 3'd0, 8'h00, 96'h0);
    step();
    chk("sat_ffff", 96'(o_drop_count), 96'hFFFF);
    chk("sat_busy", 96'(o_busy), 96'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
